score4_game_ctrl: RTL and testbench

Game-sequencing controller for the Score 4 panel. It turns the left/right/put buttons into cursor moves and piece drops, and owns the game state (panel, cursor, turn). It runs a fixed-latency sequential four-in-a-row check after every drop and drives the status outputs. Its outputs feed the VGA display block and the top-level status pins.

---
 rtl/score4_pkg.sv | 37 +++
 rtl/score4_btn_edge.sv | 27 ++
 rtl/score4_game_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_score4_game_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/score4_pkg.sv
// Shared types and defaults for the Score 4 game controller.
package score4_pkg;

  localparam int unsigned N_COLS  = 7;
  localparam int unsigned N_ROWS  = 6;
  localparam int unsigned WIN_LEN = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P_A   = 2'b01,
    P_B   = 2'b10
  } cell_t;

  typedef logic [N_COLS-1:0][N_ROWS-1:0][1:0] panel_t;

  typedef enum logic [2:0] {
    StIdle,
    StDrop,
    StCheck,
    StResult,
    StOver
  } state_t;

  typedef struct packed {
    logic signed [3:0] dcol;
    logic signed [3:0] drow;
  } dir_t;

  // Index 0..3: horizontal, vertical, diagonal, anti-diagonal.
  localparam dir_t [3:0] DIR_TABLE = {
    dir_t'{dcol: 4'sd1, drow: -4'sd1},
    dir_t'{dcol: 4'sd1, drow: 4'sd1},
    dir_t'{dcol: 4'sd0, drow: 4'sd1},
    dir_t'{dcol: 4'sd1, drow: 4'sd0}
  };

endpackage

// File: rtl/score4_btn_edge.sv
// Button front end: 2-FF synchroniser followed by a registered rising-edge pulse.
module score4_btn_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, prev_q, pulse_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/score4_game_ctrl.sv
// Score 4 game sequencer: cursor, drops, fixed-latency win check, status flags.
// Optional CURSOR_WRAP_EN: cursor wraps at the panel edges instead of saturating.
module score4_game_ctrl #(
  parameter int unsigned N_COLS  = score4_pkg::N_COLS,
  parameter int unsigned N_ROWS  = score4_pkg::N_ROWS,
  parameter int unsigned WIN_LEN = score4_pkg::WIN_LEN
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              left_i,
  input  logic                              right_i,
  input  logic                              put_i,
  output logic [N_COLS-1:0][N_ROWS-1:0][1:0] panel_o,
  output logic [N_COLS-1:0]                 play_o,
  output logic                              turn_o,
  output logic                              player_o,
  output logic                              invalid_move_o,
  output logic                              win_a_o,
  output logic                              win_b_o,
  output logic                              full_panel_o
);
  import score4_pkg::*;

  localparam int unsigned ColW  = $clog2(N_COLS);
  localparam int unsigned RowW  = $clog2(N_ROWS);
  localparam int unsigned CntW  = $clog2(N_COLS * N_ROWS + 1);
  localparam int unsigned Steps = WIN_LEN - 1;
  localparam logic signed [3:0] ColLim = 4'(N_COLS);
  localparam logic signed [3:0] RowLim = 4'(N_ROWS);
  localparam logic [N_COLS-1:0] PlayRst = N_COLS'(1) << (N_COLS / 2);
  localparam logic [CntW-1:0] CellsTotal = CntW'(N_COLS * N_ROWS);

  logic left_e, right_e, put_e;
  state_t state_q;
  logic [N_COLS-1:0][N_ROWS-1:0][1:0] panel_q;
  logic [N_COLS-1:0] play_q, play_left, play_right;
  logic turn_q, inv_q, win_a_q, win_b_q, full_q, hit_q, brk_pos_q, brk_neg_q;
  logic [ColW-1:0] col_q, cur_col;
  logic [RowW-1:0] row_q, low_row;
  logic [CntW-1:0] pieces_q;
  logic [1:0] dir_q;
  logic [2:0] sub_q;
  logic [3:0] cnt_q, cnt_nxt;
  logic col_full, pos_side, in_bounds, match, inc;
  logic signed [3:0] k_s, pcol_s, prow_s;
  logic [1:0] mover;
  dir_t dir;

  score4_btn_edge u_left  (.clk_i(clk_i), .rst_ni(rst_ni), .btn_i(left_i),  .pulse_o(left_e));
  score4_btn_edge u_right (.clk_i(clk_i), .rst_ni(rst_ni), .btn_i(right_i), .pulse_o(right_e));
  score4_btn_edge u_put   (.clk_i(clk_i), .rst_ni(rst_ni), .btn_i(put_i),   .pulse_o(put_e));

  assign mover = turn_q ? P_B : P_A;

  always_comb begin
    cur_col = '0;
    for (int i = 0; i < N_COLS; i++) begin
      if (play_q[i]) cur_col = ColW'(i);
    end
    low_row = '0;
    for (int r = N_ROWS - 1; r >= 0; r--) begin
      if (panel_q[cur_col][r] == EMPTY) low_row = RowW'(r);
    end
  end

  assign col_full = panel_q[cur_col][N_ROWS-1] != EMPTY;

  // sub_q 0..Steps-1 probes offsets +1..+Steps, the rest probe -1..-Steps.
  always_comb begin
    dir       = DIR_TABLE[dir_q];
    pos_side  = sub_q < 3'(Steps);
    k_s       = pos_side ? 4'(sub_q) + 4'd1 : 4'(Steps - 1) - 4'(sub_q);
    pcol_s    = $signed(4'(col_q)) + k_s * dir.dcol;
    prow_s    = $signed(4'(row_q)) + k_s * dir.drow;
    in_bounds = (pcol_s >= 4'sd0) && (pcol_s < ColLim) && (prow_s >= 4'sd0) && (prow_s < RowLim);
    match     = in_bounds && (panel_q[pcol_s[ColW-1:0]][prow_s[RowW-1:0]] == mover);
    inc       = match && (pos_side ? !brk_pos_q : !brk_neg_q);
    cnt_nxt   = cnt_q + {3'b000, inc};
  end

`ifdef CURSOR_WRAP_EN
  assign play_left  = {play_q[0], play_q[N_COLS-1:1]};
  assign play_right = {play_q[N_COLS-2:0], play_q[N_COLS-1]};
`else
  assign play_left  = play_q[0] ? play_q : play_q >> 1;
  assign play_right = play_q[N_COLS-1] ? play_q : play_q << 1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      panel_q   <= '0;
      play_q    <= PlayRst;
      turn_q    <= 1'b0;
      inv_q     <= 1'b0;
      win_a_q   <= 1'b0;
      win_b_q   <= 1'b0;
      full_q    <= 1'b0;
      hit_q     <= 1'b0;
      brk_pos_q <= 1'b0;
      brk_neg_q <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      pieces_q  <= '0;
      dir_q     <= '0;
      sub_q     <= '0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (put_e) begin
            if (col_full) begin
              inv_q <= 1'b1;
            end else begin
              inv_q   <= 1'b0;
              col_q   <= cur_col;
              row_q   <= low_row;
              state_q <= StDrop;
            end
          end else if (left_e ^ right_e) begin
            inv_q  <= 1'b0;
            play_q <= left_e ? play_left : play_right;
          end
        end
        StDrop: begin
          panel_q[col_q][row_q] <= mover;
          pieces_q  <= pieces_q + 1'b1;
          dir_q     <= '0;
          sub_q     <= '0;
          cnt_q     <= 4'd1;
          brk_pos_q <= 1'b0;
          brk_neg_q <= 1'b0;
          hit_q     <= 1'b0;
          state_q   <= StCheck;
        end
        StCheck: begin
          if (cnt_nxt >= 4'(WIN_LEN)) hit_q <= 1'b1;
          if (pos_side && !match) brk_pos_q <= 1'b1;
          if (!pos_side && !match) brk_neg_q <= 1'b1;
          cnt_q <= cnt_nxt;
          if (sub_q == 3'(2 * Steps - 1)) begin
            sub_q     <= '0;
            dir_q     <= dir_q + 2'd1;
            cnt_q     <= 4'd1;
            brk_pos_q <= 1'b0;
            brk_neg_q <= 1'b0;
            if (dir_q == 2'd3) state_q <= StResult;
          end else begin
            sub_q <= sub_q + 3'd1;
          end
        end
        StResult: begin
          if (pieces_q == CellsTotal) full_q <= 1'b1;
          if (hit_q) begin
            if (turn_q) win_b_q <= 1'b1;
            else win_a_q <= 1'b1;
            state_q <= StOver;
          end else if (pieces_q == CellsTotal) begin
            state_q <= StOver;
          end else begin
            turn_q  <= ~turn_q;
            state_q <= StIdle;
          end
        end
        StOver: state_q <= StOver;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign panel_o        = panel_q;
  assign play_o         = play_q;
  assign turn_o         = turn_q;
  assign player_o       = turn_q;
  assign invalid_move_o = inv_q;
  assign win_a_o        = win_a_q;
  assign win_b_o        = win_b_q;
  assign full_panel_o   = full_q;

endmodule

// File: tb/tb_score4_game_ctrl.sv
// Directed bench for score4_game_ctrl with a queue-based expected-value scoreboard.
module tb_score4_game_ctrl;

  logic clk = 1'b0;
  logic rst_ni, left_i, right_i, put_i;
  logic [6:0][5:0][1:0] panel_o;
  logic [6:0] play_o;
  logic turn_o, player_o, invalid_move_o, win_a_o, win_b_o, full_panel_o;

  int errors = 0;
  int checks = 0;
  string tag_q[$];
  logic [95:0] exp_q[$];

  // Reference model of the game state.
  logic [6:0][5:0][1:0] m_panel;
  int m_h[7];
  int cur;
  logic m_turn, m_inv, m_wa, m_wb, m_full;

  always #5 clk = ~clk;

  score4_game_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .left_i(left_i), .right_i(right_i), .put_i(put_i),
    .panel_o(panel_o), .play_o(play_o), .turn_o(turn_o), .player_o(player_o),
    .invalid_move_o(invalid_move_o), .win_a_o(win_a_o), .win_b_o(win_b_o),
    .full_panel_o(full_panel_o)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] obs_status();
    return {play_o, turn_o, player_o, invalid_move_o, win_a_o, win_b_o, full_panel_o};
  endfunction

  function automatic logic [12:0] exp_status();
    logic [6:0] oh;
    oh = 7'b1 << cur;
    return {oh, m_turn, m_turn, m_inv, m_wa, m_wb, m_full};
  endfunction

  task automatic push(input string t, input logic [95:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic check_next(input logic [95:0] obs);
    string t;
    logic [95:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow observed=%0h expected=<none>", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
    end
  endtask

  task automatic model_reset();
    m_panel = '0;
    foreach (m_h[i]) m_h[i] = 0;
    cur = 3;
    m_turn = 1'b0;
    m_inv = 1'b0;
    m_wa = 1'b0;
    m_wb = 1'b0;
    m_full = 1'b0;
  endtask

  task automatic check_reset_now(input string t);
    model_reset();
    push({t, "_status"}, 96'(exp_status()));
    check_next(96'(obs_status()));
    push({t, "_panel"}, 96'(m_panel));
    check_next(96'(panel_o));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    check_reset_now("reset");
    tick(2);
    rst_ni = 1'b1;
    tick(2);
  endtask

  // Cursor button pulse; dir 0 = left, 1 = right.
  task automatic pulse(input bit dir);
    if (dir) right_i = 1'b1;
    else left_i = 1'b1;
    tick(4);
    if (!(m_wa || m_wb || m_full)) begin
      if (!dir && cur > 0) cur--;
      if (dir && cur < 6) cur++;
      m_inv = 1'b0;
    end
    push(dir ? "right_e1" : "left_e1", 96'(exp_status()));
    check_next(96'(obs_status()));
    left_i = 1'b0;
    right_i = 1'b0;
    tick(3);
  endtask

  task automatic move_to(input int c);
    while (cur < c) pulse(1'b1);
    while (cur > c) pulse(1'b0);
  endtask

  // res: 0 game continues, 1 mover wins, 2 board fills.
  task automatic put_at(input int c, input int res, input bit inject_left);
    move_to(c);
    if (m_h[c] == 6) begin
      m_inv = 1'b1;
      push("put_full_e1", 96'(exp_status()));
      put_i = 1'b1;
      tick(4);
      check_next(96'(obs_status()));
      push("put_full_panel", 96'(m_panel));
      tick(1);
      check_next(96'(panel_o));
      put_i = 1'b0;
      tick(3);
      return;
    end
    m_inv = 1'b0;
    push("put_e1", 96'(exp_status()));
    put_i = 1'b1;
    tick(4);
    check_next(96'(obs_status()));
    m_panel[c][m_h[c]] = m_turn ? 2'b10 : 2'b01;
    m_h[c]++;
    push("put_e2_panel", 96'(m_panel));
    tick(1);
    check_next(96'(panel_o));
    put_i = 1'b0;
    push("put_e26", 96'(exp_status()));
    if (inject_left) begin
      tick(3);
      left_i = 1'b1;
      tick(5);
      left_i = 1'b0;
      tick(16);
    end else begin
      tick(24);
    end
    check_next(96'(obs_status()));
    if (res == 1) begin
      if (m_turn) m_wb = 1'b1;
      else m_wa = 1'b1;
    end else if (res == 2) begin
      m_full = 1'b1;
    end else begin
      m_turn = ~m_turn;
    end
    push("put_e27", 96'(exp_status()));
    tick(1);
    check_next(96'(obs_status()));
  endtask

  task automatic put_ignored();
    push("over_put_e1", 96'(exp_status()));
    put_i = 1'b1;
    tick(4);
    check_next(96'(obs_status()));
    put_i = 1'b0;
    tick(26);
    push("over_put_status", 96'(exp_status()));
    check_next(96'(obs_status()));
    push("over_put_panel", 96'(m_panel));
    check_next(96'(panel_o));
  endtask

  int draw_order[7] = '{0, 2, 1, 3, 4, 6, 5};
  int row_win[7] = '{0, 0, 1, 1, 2, 2, 3};
  int diag_win[10] = '{2, 1, 3, 2, 4, 3, 4, 3, 4, 4};

  initial begin
    rst_ni = 1'b0;
    left_i = 1'b0;
    right_i = 1'b0;
    put_i = 1'b0;
    tick(2);
    check_reset_now("init");
    rst_ni = 1'b1;
    tick(2);

    // Cursor moves, then one put with a left edge arriving mid-check.
    pulse(1'b1);
    pulse(1'b1);
    put_at(3, 0, 1'b1);

    // Fill column 0, overfill, then a cursor move clears invalid_move.
    for (int i = 0; i < 6; i++) put_at(0, 0, 1'b0);
    put_at(0, 0, 1'b0);
    pulse(1'b1);

    // Horizontal win for A on row 0.
    do_reset();
    for (int i = 0; i < 7; i++) put_at(row_win[i], (i == 6) ? 1 : 0, 1'b0);
    put_ignored();
    pulse(1'b1);

    // Diagonal win for B.
    do_reset();
    for (int i = 0; i < 10; i++) put_at(diag_win[i], (i == 9) ? 1 : 0, 1'b0);
    put_ignored();

    // 42-move draw.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 7; i++) put_at(draw_order[i], (r == 5 && i == 6) ? 2 : 0, 1'b0);
    end
    put_ignored();

    // Second game: reset during DROP, then during CHECK.
    do_reset();
    put_i = 1'b1;
    tick(4);
    rst_ni = 1'b0;
    #1;
    check_reset_now("rst_mid_drop");
    put_i = 1'b0;
    tick(2);
    rst_ni = 1'b1;
    tick(3);
    put_i = 1'b1;
    tick(5);
    put_i = 1'b0;
    tick(8);
    rst_ni = 1'b0;
    #1;
    check_reset_now("rst_mid_check");
    tick(2);
    rst_ni = 1'b1;
    tick(3);
    put_at(3, 0, 1'b0);

    checks++;
    assert (exp_q.size() === 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
